// File: rtl/wb_slave_mux.sv
// wb_slave_mux: Wishbone classic slave-side fan-out to NSLV peripherals.
// The slave-select field of the address picks one downstream slave. Strobes
// and the master ack are registered. A per-transaction watchdog turns a
// silent slave into an error response. Unmapped and timed-out accesses
// return DEFAULT_DATA and raise sticky fault flags plus a fault interrupt.
module wb_slave_mux #(
    parameter int          NSLV         = 4,
    parameter int          SEL_LSB      = 16,
    parameter int          SEL_W        = 4,
    parameter int          TIMEOUT      = 255,
    parameter logic [31:0] DEFAULT_DATA = 32'hDEADBEEF
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_stb_i,
    input  logic                 wbs_we_i,
    input  logic [3:0]           wbs_sel_i,
    input  logic [31:0]          wbs_adr_i,
    input  logic [31:0]          wbs_dat_i,
    output logic                 wbs_ack_o,
    output logic [31:0]          wbs_dat_o,
    output logic [NSLV-1:0]      s_cyc_o,
    output logic [NSLV-1:0]      s_stb_o,
    output logic                 s_we_o,
    output logic [3:0]           s_sel_o,
    output logic [31:0]          s_adr_o,
    output logic [31:0]          s_dat_o,
    input  logic [NSLV-1:0]      s_ack_i,
    input  logic [NSLV*32-1:0]   s_dat_i,
    input  logic                 fault_clr_i,
    output logic [1:0]           fault_status_o,
    output logic [31:0]          fault_addr_o,
    output logic                 fault_irq_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // Counter only needs to reach TIMEOUT-1; the expiry test looks one ahead.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int TO_M1 = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    logic [1:0]       state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      dat_q, dat_d;
    logic             ack_q, ack_d;
    logic [NSLV-1:0]  stb_q, stb_d;
    logic [1:0]       status_q, status_d;
    logic [31:0]      faddr_q, faddr_d;
    logic             irq_q, irq_d;

    logic [SEL_W-1:0] idx_in;
    logic             mapped_in;
    logic             ack_sel;
    logic [31:0]      dat_sel;
    logic [1:0]       fault_set;

    assign idx_in    = wbs_adr_i[SEL_LSB +: SEL_W];
    assign mapped_in = ({{(32-SEL_W){1'b0}}, idx_in} < 32'(NSLV));

    assign s_we_o  = wbs_we_i;
    assign s_sel_o = wbs_sel_i;
    assign s_adr_o = wbs_adr_i;
    assign s_dat_o = wbs_dat_i;

    assign wbs_ack_o      = ack_q;
    assign wbs_dat_o      = dat_q;
    assign s_cyc_o        = stb_q;
    assign s_stb_o        = stb_q;
    assign fault_status_o = status_q;
    assign fault_addr_o   = faddr_q;
    assign fault_irq_o    = irq_q;

    // Pick the ack and read data of the currently selected slave only.
    always_comb begin
        ack_sel = 1'b0;
        dat_sel = 32'h0;
        for (int k = 0; k < NSLV; k++) begin
            if (idx_q == SEL_W'(k)) begin
                ack_sel = s_ack_i[k];
                dat_sel = s_dat_i[k*32 +: 32];
            end
        end
    end

    // Transaction FSM: accept/decode, wait for the slave or the watchdog, respond.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        dat_d     = dat_q;
        faddr_d   = faddr_q;
        fault_set = 2'b00;
        case (state_q)
            IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    idx_d = idx_in;
                    if (mapped_in) begin
                        state_d = WAIT;
                        cnt_d   = '0;
                    end else begin
                        state_d      = RESP;
                        dat_d        = DEFAULT_DATA;
                        fault_set[0] = 1'b1;
                        faddr_d      = wbs_adr_i;
                    end
                end
            end
            WAIT: begin
                if (!wbs_cyc_i) begin
                    // Master abandoned the cycle: quietly release the slave.
                    state_d = IDLE;
                end else if (ack_sel) begin
                    // Checked before expiry so a same-edge ack beats the watchdog.
                    state_d = RESP;
                    dat_d   = dat_sel;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TO_M1))) begin
                    state_d      = RESP;
                    dat_d        = DEFAULT_DATA;
                    fault_set[1] = 1'b1;
                    faddr_d      = wbs_adr_i;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered outputs derived from the next state; set beats clear on status.
    always_comb begin
        ack_d = (state_d == RESP);
        stb_d = '0;
        if (state_d == WAIT) begin
            for (int k = 0; k < NSLV; k++) begin
                if (idx_d == SEL_W'(k)) begin
                    stb_d[k] = 1'b1;
                end
            end
        end
        status_d = (fault_clr_i ? 2'b00 : status_q) | fault_set;
        irq_d    = |status_d;
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            dat_q    <= 32'h0;
            ack_q    <= 1'b0;
            stb_q    <= '0;
            status_q <= 2'b00;
            faddr_q  <= 32'h0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            dat_q    <= dat_d;
            ack_q    <= ack_d;
            stb_q    <= stb_d;
            status_q <= status_d;
            faddr_q  <= faddr_d;
            irq_q    <= irq_d;
        end
    end

endmodule

// File: tb/tb_wb_slave_mux.sv
// tb_wb_slave_mux: directed vector table plus hand-written sequences for
// abort, clear/set collision and asynchronous reset mid-transaction.
module tb_wb_slave_mux;

    localparam int NSLV = 4;

    logic              clk;
    logic              rst_n;
    logic              wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]        wbs_sel_i;
    logic [31:0]       wbs_adr_i, wbs_dat_i;
    logic              wbs_ack_o;
    logic [31:0]       wbs_dat_o;
    logic [NSLV-1:0]   s_cyc_o, s_stb_o;
    logic              s_we_o;
    logic [3:0]        s_sel_o;
    logic [31:0]       s_adr_o, s_dat_o;
    logic [NSLV-1:0]   s_ack_i;
    logic [NSLV*32-1:0] s_dat_i;
    logic              fault_clr_i;
    logic [1:0]        fault_status_o;
    logic [31:0]       fault_addr_o;
    logic              fault_irq_o;

    wb_slave_mux #(
        .NSLV(NSLV), .SEL_LSB(16), .SEL_W(4), .TIMEOUT(8), .DEFAULT_DATA(32'hDEADBEEF)
    ) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
        .fault_clr_i(fault_clr_i), .fault_status_o(fault_status_o),
        .fault_addr_o(fault_addr_o), .fault_irq_o(fault_irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    // dly: strobe cycles the slave lets pass before acking (-1 = never acks).
    typedef struct {
        logic [31:0] adr;
        logic        we;
        int          dly;
        logic [31:0] sdata;
        logic        noise;
        int          e_ack;
        logic [31:0] e_dat;
        logic [3:0]  e_stb;
        int          e_stbc;
        logic [1:0]  e_st;
        logic [31:0] e_fa;
    } vec_t;

    vec_t vecs[9];

    // Runs one master access starting just after a clock edge. Cycle n is the
    // cycle following edge n-1, edge 0 being the accept edge.
    task automatic run_txn(input vec_t v, input string tag, output int ack_cyc,
                           output logic [31:0] rd, output int stbc, output logic [3:0] stb_or);
        int tgt;
        tgt     = int'(v.adr[19:16]);
        ack_cyc = -1;
        rd      = 32'h0;
        stbc    = 0;
        stb_or  = 4'h0;
        for (int k = 0; k < NSLV; k++) s_dat_i[k*32 +: 32] = 32'hBAD0_0000 | k;
        if (tgt < NSLV) s_dat_i[tgt*32 +: 32] = v.sdata;
        wbs_adr_i = v.adr;
        wbs_we_i  = v.we;
        wbs_sel_i = 4'hA;
        wbs_dat_i = ~v.sdata;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                check({tag, " fwd_adr"}, s_adr_o, v.adr);
                check({tag, " fwd_ctl"}, {26'h0, s_we_o, s_sel_o, 1'b0}, {26'h0, v.we, 4'hA, 1'b0});
                check({tag, " fwd_dat"}, s_dat_o, ~v.sdata);
            end
            if (wbs_ack_o) begin
                ack_cyc = n;
                rd      = wbs_dat_o;
                check({tag, " stb_low_at_ack"}, {28'h0, s_stb_o}, 32'h0);
                break;
            end
            stb_or |= s_stb_o;
            if (tgt < NSLV && s_stb_o[tgt]) stbc++;
            s_ack_i = 4'h0;
            if (tgt < NSLV) begin
                if (v.noise) s_ack_i = ~(4'b0001 << tgt);
                if (s_stb_o[tgt] && v.dly >= 0 && stbc > v.dly) s_ack_i[tgt] = 1'b1;
            end
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        s_ack_i   = 4'h0;
    endtask

    task automatic clear_faults();
        fault_clr_i = 1'b1;
        @(posedge clk); #1;
        fault_clr_i = 1'b0;
        check("clr_status", {30'h0, fault_status_o}, 32'h0);
    endtask

    int          ack_cyc, stbc;
    logic [31:0] rd;
    logic [3:0]  stb_or;
    logic        seen_ack;
    int          cnt;

    initial begin
        vecs[0] = '{32'h0002_0010, 1'b0,  1, 32'h1234_5678, 1'b0, 3, 32'h1234_5678, 4'b0100, 2, 2'b00, 32'h0};
        vecs[1] = '{32'h0000_0004, 1'b0,  0, 32'hA5A5_0001, 1'b0, 2, 32'hA5A5_0001, 4'b0001, 1, 2'b00, 32'h0};
        vecs[2] = '{32'h0003_FFFC, 1'b1,  2, 32'h0BAD_F00D, 1'b1, 4, 32'h0BAD_F00D, 4'b1000, 3, 2'b00, 32'h0};
        vecs[3] = '{32'h0009_0000, 1'b0,  0, 32'h0,         1'b0, 1, 32'hDEAD_BEEF, 4'b0000, 0, 2'b01, 32'h0009_0000};
        vecs[4] = '{32'h0004_0000, 1'b1,  0, 32'h0,         1'b0, 1, 32'hDEAD_BEEF, 4'b0000, 0, 2'b01, 32'h0004_0000};
        vecs[5] = '{32'h0001_0020, 1'b0, -1, 32'h5555_AAAA, 1'b0, 9, 32'hDEAD_BEEF, 4'b0010, 8, 2'b10, 32'h0001_0020};
        vecs[6] = '{32'h0001_0024, 1'b0,  7, 32'hCAFE_0007, 1'b0, 9, 32'hCAFE_0007, 4'b0010, 8, 2'b00, 32'h0};
        vecs[7] = '{32'h0003_0008, 1'b0,  6, 32'h1111_2222, 1'b1, 8, 32'h1111_2222, 4'b1000, 7, 2'b00, 32'h0};
        vecs[8] = '{32'hFFF2_0000, 1'b0,  0, 32'h7777_8888, 1'b0, 2, 32'h7777_8888, 4'b0100, 1, 2'b00, 32'h0};

        rst_n = 1'b0;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'h0; wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
        s_ack_i = 4'h0; s_dat_i = '0; fault_clr_i = 1'b0;
        #12;
        check("rst_ack", {31'h0, wbs_ack_o}, 32'h0);
        check("rst_dat", wbs_dat_o, 32'h0);
        check("rst_strobes", {24'h0, s_cyc_o, s_stb_o}, 32'h0);
        check("rst_fault", {29'h0, fault_irq_o, fault_status_o}, 32'h0);
        check("rst_faddr", fault_addr_o, 32'h0);
        #10;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            clear_faults();
            run_txn(vecs[i], tag, ack_cyc, rd, stbc, stb_or);
            check({tag, " ack_cycle"}, ack_cyc, vecs[i].e_ack);
            check({tag, " rdata"}, rd, vecs[i].e_dat);
            check({tag, " stb_seen"}, {28'h0, stb_or}, {28'h0, vecs[i].e_stb});
            check({tag, " stb_cycles"}, stbc, vecs[i].e_stbc);
            @(posedge clk); #1;
            check({tag, " ack_one_cycle"}, {31'h0, wbs_ack_o}, 32'h0);
            check({tag, " status"}, {30'h0, fault_status_o}, {30'h0, vecs[i].e_st});
            check({tag, " irq"}, {31'h0, fault_irq_o}, {31'h0, |vecs[i].e_st});
            if (vecs[i].e_st != 2'b00) check({tag, " faddr"}, fault_addr_o, vecs[i].e_fa);
        end

        // Abort: leave a timeout flag set, then drop cyc in the 3rd WAIT cycle.
        clear_faults();
        run_txn(vecs[5], "to_pre", ack_cyc, rd, stbc, stb_or);
        @(posedge clk); #1;
        check("abort_pre_status", {30'h0, fault_status_o}, 32'h2);
        wbs_adr_i = 32'h0001_0040; wbs_we_i = 1'b0;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        cnt = 0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (s_stb_o[1]) cnt++;
            if (cnt == 3) break;
        end
        check("abort_stb_cycles", cnt, 3);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(posedge clk); #1;
        check("abort_strobes_low", {24'h0, s_cyc_o, s_stb_o}, 32'h0);
        seen_ack = wbs_ack_o;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            seen_ack |= wbs_ack_o;
        end
        check("abort_no_ack", {31'h0, seen_ack}, 32'h0);
        check("abort_status", {30'h0, fault_status_o}, 32'h2);

        // Clear pulse on the same edge as a new unmapped fault.
        wbs_adr_i = 32'h000A_0000; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        fault_clr_i = 1'b1;
        @(posedge clk); #1;
        fault_clr_i = 1'b0;
        check("coll_ack", {31'h0, wbs_ack_o}, 32'h1);
        check("coll_dat", wbs_dat_o, 32'hDEAD_BEEF);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(posedge clk); #1;
        check("coll_status", {30'h0, fault_status_o}, 32'h1);
        check("coll_faddr", fault_addr_o, 32'h000A_0000);

        // Asynchronous reset in the middle of WAIT.
        wbs_adr_i = 32'h0002_0000; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_stb_before", {28'h0, s_stb_o}, 32'h4);
        rst_n = 1'b0;
        #2;
        check("mid_rst_strobes", {24'h0, s_cyc_o, s_stb_o}, 32'h0);
        check("mid_rst_ack_dat", {wbs_dat_o[31:1], wbs_ack_o}, 32'h0);
        check("mid_rst_fault", {29'h0, fault_irq_o, fault_status_o}, 32'h0);
        check("mid_rst_faddr", fault_addr_o, 32'h0);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_txn(vecs[1], "post_rst", ack_cyc, rd, stbc, stb_or);
        check("post_rst ack_cycle", ack_cyc, 2);
        check("post_rst rdata", rd, 32'hA5A5_0001);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wb_slave_mux.md
Name: wb_slave_mux

Overview:
- Parametrised Wishbone classic slave-side interconnect, successor to the fixed 3-peripheral decoder in user_project.
- Fans one Wishbone slave port out to NSLV peripherals, selected by an address field.
- Adds registered strobes and a per-transaction timeout watchdog.
- Unmapped and timed-out accesses get a DEFAULT_DATA error response; sticky fault status, fault address capture and a fault interrupt are provided.

Parameters:
- NSLV, 4, number of downstream slaves (1..16).
- SEL_LSB, 16, LSB of the slave-select field in wbs_adr_i.
- SEL_W, 4, width of the slave-select field; requires 2^SEL_W >= NSLV.
- TIMEOUT, 255, cycles to wait for a slave ack before forcing an error response; 0 disables the watchdog.
- DEFAULT_DATA, 32'hDEADBEEF, read data returned on unmapped or timed-out accesses.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_ni  in  1  asynchronous active-low reset
- wbs_cyc_i  in  1  master cycle
- wbs_stb_i  in  1  master strobe
- wbs_we_i  in  1  master write enable
- wbs_sel_i  in  4  master byte selects
- wbs_adr_i  in  32  master address
- wbs_dat_i  in  32  master write data
- wbs_ack_o  out  1  ack to master
- wbs_dat_o  out  32  read data to master
- s_cyc_o  out  NSLV  per-slave cycle
- s_stb_o  out  NSLV  per-slave strobe
- s_we_o  out  1  forwarded wbs_we_i
- s_sel_o  out  4  forwarded wbs_sel_i
- s_adr_o  out  32  forwarded wbs_adr_i
- s_dat_o  out  32  forwarded wbs_dat_i
- s_ack_i  in  NSLV  per-slave ack
- s_dat_i  in  NSLV*32  per-slave read data; slave k occupies bits [32k+31:32k]
- fault_clr_i  in  1  one-cycle pulse clearing fault status
- fault_status_o  out  2  sticky flags: bit0 = unmapped, bit1 = timeout
- fault_addr_o  out  32  address of the most recent faulting access
- fault_irq_o  out  1  OR of fault_status_o

Behaviour:
- Reset (wb_rst_ni low, async): state IDLE; wbs_ack_o=0; wbs_dat_o=0; s_cyc_o=0; s_stb_o=0; fault_status_o=0; fault_addr_o=0; fault_irq_o=0; timeout counter=0.
- Forwarding: s_we_o, s_sel_o, s_adr_o and s_dat_o are combinational pass-throughs of the master signals. The master holds them stable until ack.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On wbs_cyc_i & wbs_stb_i at a clock edge, latch idx = wbs_adr_i[SEL_LSB+SEL_W-1:SEL_LSB].
  - If idx < NSLV, go to WAIT.
  - Otherwise go to RESP with error: wbs_dat_o=DEFAULT_DATA, set status bit0, fault_addr_o=wbs_adr_i.
- WAIT:
  - s_cyc_o[idx]=s_stb_o[idx]=1; all other bits 0. Outputs are registered, so they are high from the first cycle after accept.
  - On s_ack_i[idx]: register s_dat_i slice idx into wbs_dat_o and go to RESP.
  - Acks from non-selected slaves are ignored.
- RESP:
  - wbs_ack_o=1 for exactly one cycle; all slave strobes low; then IDLE.
  - A master still strobing is re-sampled in IDLE, so back-to-back throughput is 1 transfer per 3 cycles minimum.
- Latency, counting edge 0 as the accept edge:
  - Mapped access acked by its slave in the first WAIT cycle: wbs_ack_o high in cycle 2.
  - Unmapped access: wbs_ack_o high in cycle 1.
- Watchdog:
  - Counter clears on entry to WAIT and increments each WAIT cycle without the selected ack.
  - When TIMEOUT!=0 and the count reaches TIMEOUT without an ack: go to RESP with wbs_dat_o=DEFAULT_DATA, set status bit1, capture fault_addr_o.
  - If the ack and the timeout occur on the same edge, the ack wins.
- Abort: if wbs_cyc_i drops during WAIT, go to IDLE next edge, drop the slave strobes, issue no ack and flag no fault.
- Writes use the same FSM. wbs_dat_o still updates (slave data, or DEFAULT_DATA on error).
- Fault status:
  - Bits are sticky and cleared by fault_clr_i.
  - If a set and fault_clr_i occur on the same edge, the set wins.
  - fault_addr_o holds the most recent faulting address; fault_clr_i does not clear it.
- fault_irq_o is registered: |fault_status_o.
- Reset asserted mid-transaction returns the block to IDLE immediately, with all strobes and the ack low.

Test Plan:
- Read slave 2 at adr 0x0002_0010; slave returns 0x1234_5678 with ack one cycle after s_stb_o[2] rises -> s_stb_o=4'b0100 only; wbs_ack_o high one cycle; wbs_dat_o=0x1234_5678; no fault.
- Access adr 0x0009_0000 with NSLV=4 -> wbs_ack_o high one cycle after accept; wbs_dat_o=0xDEADBEEF; fault_status_o=2'b01; fault_addr_o=0x0009_0000; fault_irq_o=1; no slave strobe.
- Slave 1 never acks, TIMEOUT=8 -> s_stb_o[1] held 8 cycles, then wbs_ack_o with 0xDEADBEEF; fault_status_o bit1=1; strobe dropped.
- Slave ack arrives on the exact TIMEOUT edge -> slave data returned; no timeout flag set.
- wbs_cyc_i dropped in the 3rd WAIT cycle -> strobes low next cycle; no wbs_ack_o; fault_status_o unchanged. Then pulse fault_clr_i coincident with a new unmapped fault -> bit0 remains set.
- wb_rst_ni pulsed low during WAIT -> all outputs return to reset values asynchronously; the next access completes normally.
